// File: rtl/aes_pkg.sv
// aes_pkg: shared types and constants for the AES input loader.
package aes_pkg;
  typedef enum logic [2:0] {HDR, KEY, DATA, START, WAIT} loader_state_t;
  localparam int HDR_DECRYPT_BIT = 0;
  localparam int HDR_NEWKEY_BIT = 1;
  localparam int AES_BLOCK_BITS = 128;
endpackage

// File: rtl/aes_byte_shifter.sv
// aes_byte_shifter: 128-bit register that shifts in one byte at the bottom per enable.
module aes_byte_shifter
  import aes_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [7:0]                din,
  output logic [AES_BLOCK_BITS-1:0] q
);
  logic [AES_BLOCK_BITS-1:0] data_q, data_d;
  always_comb data_d = en ? {data_q[AES_BLOCK_BITS-9:0], din} : data_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) data_q <= '0;
    else data_q <= data_d;
  assign q = data_q;
endmodule

// File: rtl/aes_input_loader.sv
// aes_input_loader: framed byte stream to 128-bit key/data operands with start pulses to the aes core.
module aes_input_loader
  import aes_pkg::*;
#(
  parameter int BLOCK_BYTES = 16,
  parameter int KEY_BYTES   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [7:0]                in_byte,
  output logic [AES_BLOCK_BITS-1:0] aes_key,
  output logic [AES_BLOCK_BITS-1:0] aes_data,
  output logic                      start_encryption,
  output logic                      start_decryption,
  input  logic                      aes_done,
  output logic                      busy,
  output logic                      err_nokey
);
  loader_state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic dec_q, dec_d, drop_q, drop_d, key_valid_q, key_valid_d;
  logic in_ready_q, in_ready_d, start_enc_q, start_enc_d, start_dec_q, start_dec_d;
  logic busy_q, busy_d, err_q, err_d;
  logic accept, last_key, last_data;
  assign accept    = in_valid && in_ready_q;
  assign last_key  = cnt_q == 4'(KEY_BYTES - 1);
  assign last_data = cnt_q == 4'(BLOCK_BYTES - 1);
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dec_d       = dec_q;
    drop_d      = drop_q;
    key_valid_d = key_valid_q;
    start_enc_d = 1'b0;
    start_dec_d = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      HDR: if (accept) begin
        dec_d   = in_byte[HDR_DECRYPT_BIT];
        drop_d  = !in_byte[HDR_NEWKEY_BIT] && !key_valid_q;
        err_d   = drop_d;
        state_d = in_byte[HDR_NEWKEY_BIT] ? KEY : DATA;
      end
      KEY: if (accept) begin
        cnt_d = cnt_q + 4'd1;
        if (last_key) begin
          key_valid_d = 1'b1;
          state_d     = DATA;
        end
      end
      DATA: if (accept) begin
        cnt_d = cnt_q + 4'd1;
        if (last_data) begin
          state_d     = drop_q ? HDR : START;
          start_enc_d = !drop_q && !dec_q;
          start_dec_d = !drop_q && dec_q;
        end
      end
      START: state_d = WAIT;
      WAIT: state_d = aes_done ? HDR : WAIT;
      default: state_d = HDR;
    endcase
    in_ready_d = state_d == HDR || state_d == KEY || state_d == DATA;
    busy_d     = state_d != HDR;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q     <= HDR;
      cnt_q       <= '0;
      dec_q       <= 1'b0;
      drop_q      <= 1'b0;
      key_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      start_enc_q <= 1'b0;
      start_dec_q <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dec_q       <= dec_d;
      drop_q      <= drop_d;
      key_valid_q <= key_valid_d;
      in_ready_q  <= in_ready_d;
      start_enc_q <= start_enc_d;
      start_dec_q <= start_dec_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  // Shifters only move in their own field state, so operands stay frozen through START and WAIT.
  aes_byte_shifter u_key (
    .clk(clk), .rst(rst), .en(accept && state_q == KEY), .din(in_byte), .q(aes_key)
  );
  aes_byte_shifter u_data (
    .clk(clk), .rst(rst), .en(accept && state_q == DATA), .din(in_byte), .q(aes_data)
  );
  assign in_ready         = in_ready_q;
  assign start_encryption = start_enc_q;
  assign start_decryption = start_dec_q;
  assign busy             = busy_q;
  assign err_nokey        = err_q;
endmodule

// File: doc/aes_input_loader.md
# aes_input_loader

Byte-stream front end that sits directly upstream of the `aes` core. It accepts framed bytes over a valid/ready handshake and assembles a 128-bit key and a 128-bit data block. It then issues a one-cycle `start_encryption` or `start_decryption` to the core and holds its operands stable until the core reports completion. The last key loaded is retained, so frames may reuse it.

## Interface
Parameters:
- `BLOCK_BYTES`, 16, bytes per data block (only 16 supported)
- `KEY_BYTES`, 16, bytes per key (only 16 supported)

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  upstream byte valid
- `in_ready`  out  1  loader can accept a byte
- `in_byte`  in  8  stream byte
- `aes_key`  out  128  assembled key to core
- `aes_data`  out  128  assembled data block to core
- `start_encryption`  out  1  one-cycle start pulse, encrypt
- `start_decryption`  out  1  one-cycle start pulse, decrypt
- `aes_done`  in  1  core completion pulse
- `busy`  out  1  high from the first header accept until return to HDR
- `err_nokey`  out  1  one-cycle pulse when a frame requests key reuse while no key is held

## Operation
- Frame format:
  - Header byte: bit0 = decrypt, bit1 = new_key, bits[7:2] ignored.
  - If new_key = 1: `KEY_BYTES` key bytes follow.
  - Then `BLOCK_BYTES` data bytes follow.
- Byte order: the first byte of a field lands in bits [127:120], the last in [7:0]. Shift left 8 bits per accepted byte.
- A byte transfers when `in_valid && in_ready` at a rising edge.
- FSM states:
  - HDR: on accept, latch decrypt and new_key, then go to KEY if new_key = 1, else DATA.
  - KEY: count 0..15. On the 16th accept, set `key_valid` and go to DATA.
  - DATA: count 0..15. On the 16th accept, go to START, or to HDR if the frame is in drop mode.
  - START: exactly one cycle; the selected start pulse is high. Then go to WAIT.
  - WAIT: stay until `aes_done` = 1, then go to HDR.
- Key reuse with `key_valid` = 0:
  - `err_nokey` pulses in the cycle after the header accept.
  - The 16 data bytes are still consumed.
  - No start pulse is issued; DATA returns directly to HDR.
- A new key overwrites the stored key only in a KEY state. `aes_key` never changes during START or WAIT.
- Byte counter: 4 bits, wraps 15 to 0 on the field's last byte.

## Timing
- Reset values: `in_ready` 0, `aes_key` 0, `aes_data` 0, both starts 0, `busy` 0, `err_nokey` 0. Internal: state HDR, counter 0, `key_valid` 0.
- `in_ready` is registered. It becomes 1 on the first rising edge after `rst` falls, is 1 throughout HDR/KEY/DATA, and is 0 in START and WAIT.
- If the last data byte is accepted at edge N:
  - Start pulse is high in cycle N..N+1 (START).
  - `in_ready` is 0 from edge N.
- If `aes_done` is sampled high at edge M in WAIT, then HDR and `in_ready` = 1 follow from edge M.
- `aes_done` is ignored outside WAIT, including the START cycle.
- `in_valid` with `in_ready` = 0 is held off, not dropped. Upstream must keep the byte stable.
- Reset mid-frame or mid-WAIT: immediate return to reset values, `key_valid` cleared, no start pulse, partial bytes discarded.
- `start_encryption` and `start_decryption` are never high together.

## Structure
- Shared package `aes_pkg`:
  - `loader_state_t` enum (HDR, KEY, DATA, START, WAIT)
  - `HDR_DECRYPT_BIT` = 0, `HDR_NEWKEY_BIT` = 1
  - `AES_BLOCK_BITS` = 128
- Sub-module `aes_byte_shifter`: a 128-bit shift register with load-enable. Instantiate it twice, once for key and once for data. The FSM and counter stay in the top.

## Test plan
- Header 0x02, key 0x00..0x0F, data 0x00112233…EEFF → `aes_key` = 0x000102…0F, `aes_data` = 0x001122…FF, `start_encryption` high 1 cycle; `aes_done` 5 cycles later → `in_ready` back to 1.
- Header 0x01 after the above, data 0x69C4…C55A → `start_decryption` high 1 cycle, `aes_key` unchanged.
- Header 0x00 straight after reset, 16 data bytes → `err_nokey` pulse 1 cycle after the header, no start pulse, returns to HDR with `in_ready` = 1.
- `in_valid` toggling every other cycle through a 33-byte frame → identical `aes_key` and `aes_data` to back-to-back delivery; bytes offered during WAIT are not accepted.
- Assert `rst` after 10 key bytes → all outputs at reset values asynchronously; a following 0x00 header gives `err_nokey`.
- `aes_done` held high during START → ignored; the loader stays in WAIT until a later `aes_done`.
